approx_adder_error_monitor: RTL and testbench
=============================================

Name: approx_adder_error_monitor

Overview:
- Downstream stage of the 8-bit approximate adders. Consumes each operand pair (a, b) with the approximate adder's result {cout, s[7:0]}, then computes the exact 9-bit sum and the error distance (ED).
- Accumulates error statistics over a frame of FRAME_LEN samples and presents them through a valid/ready result interface.
- Used on-chip to characterise accuracy of approximate adder variants against exact ripple-carry results.

Parameters:
FRAME_LEN, 256, samples per frame; legal range 1..65535
CNT_W, 16, width of sample and error counters; must satisfy 2**CNT_W > FRAME_LEN
SUM_W, 25, width of the ED sum accumulator; must be >= 9+CNT_W

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse that begins a frame; honoured only in IDLE
in_valid  in  1  sample present
in_ready  out  1  sample accepted when in_valid & in_ready
a  in  8  operand A
b  in  8  operand B
approx_s  in  8  approximate sum bits from the adder under test
approx_cout  in  1  approximate carry-out from the adder under test
res_valid  out  1  frame statistics valid
res_ready  in  1  consumer accepts statistics
err_count  out  CNT_W  number of samples with ED != 0
max_ed  out  9  largest ED in the frame
sum_ed  out  SUM_W  sum of ED over the frame
busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset (rst=1 at rising edge):
  - state=IDLE.
  - in_ready=0, res_valid=0, busy=0.
  - err_count=0, max_ed=0, sum_ed=0.
  - Sample counter and pipeline valid bits = 0.
  - Reset mid-frame discards all partial statistics.
- States: IDLE, RUN, DRAIN, REPORT.
- IDLE:
  - in_ready=0.
  - When start=1: clear err_count, max_ed, sum_ed and the sample counter, then go to RUN next cycle.
  - start in any other state is ignored.
- RUN:
  - in_ready=1.
  - Each handshake increments the sample counter.
  - The handshake that brings the count to FRAME_LEN moves the state to DRAIN. in_ready is 0 from the next cycle.
- Pipeline stage 1, registered on handshake:
  - exact = a + b, 9 bits, zero-extended.
  - approx = {approx_cout, approx_s}.
  - ED = |exact − approx|, 9 bits unsigned.
  - Stage-1 valid bit is set for the handshaken sample.
- Pipeline stage 2, on stage-1 valid:
  - sum_ed += ED.
  - err_count += (ED != 0).
  - max_ed = max(max_ed, ED).
  - Statistics reflect a sample 2 cycles after its handshake.
- DRAIN: waits until the stage-1 valid bit is 0, i.e. the last sample has been accumulated, then goes to REPORT.
- REPORT:
  - res_valid=1, busy=0.
  - Outputs held stable until res_valid & res_ready. Go to IDLE on that cycle.
  - Statistics remain readable in IDLE until the next start.
- FRAME_LEN=1: a single handshake moves RUN straight to DRAIN.
- Arithmetic:
  - Width rules guarantee no overflow: max sum_ed = 511*FRAME_LEN.
  - No saturation or wrap is needed.
- A start pulse coinciding with res_ready in REPORT is ignored. Only start while already in IDLE is honoured.
- in_valid with in_ready=0 is not consumed. Inputs need not be held stable while unaccepted.

Optional Feature:
- Macro: APPROX_MON_BIAS_EN.
- Defined:
  - Adds output port bias_sum, signed, width SUM_W+1.
  - Accumulates the signed error (exact − approx) in stage 2 alongside sum_ed.
  - Cleared on start and reset; valid with res_valid.
- Not defined:
  - Port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset, then FRAME_LEN=4, start. Drive a=0x0F,b=0x01,approx=0x010 four times → res_valid; err_count=0, max_ed=0, sum_ed=0.
2. FRAME_LEN=4. Drive samples (0xC0,0xC0,approx 0x0C0), (0x01,0x01,approx 0x002), (0xFF,0x01,approx 0x0FF), (0x10,0x20,approx 0x031) → err_count=3, max_ed=192, sum_ed=192+0+1+1=194. With APPROX_MON_BIAS_EN: bias_sum=192+0+1−1=192.
3. Toggle in_valid every other cycle, and hold res_ready=0 for 5 cycles in REPORT → statistics match scenario 2; outputs stable while res_valid=1 and res_ready=0; IDLE entered the cycle after res_ready=1.
4. Assert rst after 2 of 4 samples → all outputs 0, state IDLE. A new start with 4 fresh samples produces statistics covering only the new samples.
5. Pulse start during RUN and during REPORT → no effect; counts unchanged. Pulse start in IDLE after REPORT → accumulators clear.
6. FRAME_LEN=1, single sample a=0x80,b=0x80,approx=0x000 → err_count=1, max_ed=256, sum_ed=256; res_valid asserted 3 cycles after the handshake.

Source files
------------

// File: rtl/approx_adder_error_monitor_if.sv
// Sample and result channels of the approximate-adder error monitor.
// bias_sum exists only when APPROX_MON_BIAS_EN is defined.
interface approx_adder_error_monitor_if #(
    parameter int CNT_W = 16,
    parameter int SUM_W = 25
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [7:0]       approx_s;
    logic             approx_cout;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] err_count;
    logic [8:0]       max_ed;
    logic [SUM_W-1:0] sum_ed;
`ifdef APPROX_MON_BIAS_EN
    logic signed [SUM_W:0] bias_sum;
`endif

    modport slave (
        input  in_valid, a, b, approx_s, approx_cout, res_ready,
        output in_ready, res_valid, err_count, max_ed, sum_ed
`ifdef APPROX_MON_BIAS_EN
        , bias_sum
`endif
    );

    modport master (
        output in_valid, a, b, approx_s, approx_cout, res_ready,
        input  in_ready, res_valid, err_count, max_ed, sum_ed
`ifdef APPROX_MON_BIAS_EN
        , bias_sum
`endif
    );
endinterface

// File: rtl/approx_adder_error_monitor.sv
// Frame-based error-distance statistics for an 8-bit approximate adder.
// Optional signed-bias accumulator enabled by APPROX_MON_BIAS_EN.
module approx_adder_error_monitor #(
    parameter int FRAME_LEN = 256,
    parameter int CNT_W     = 16,
    parameter int SUM_W     = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o,
    approx_adder_error_monitor_if.slave mon
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clr;
    logic             hs;
    logic             last;

    logic [8:0]       exact, approx, ed;
    logic             v1_q;
    logic [8:0]       ed1_q;

    logic [CNT_W-1:0] err_q;
    logic [8:0]       max_q;
    logic [SUM_W-1:0] sum_q;

    assign hs   = mon.in_valid & mon.in_ready;
    assign last = (cnt_q == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                clr     = 1'b1;
                state_d = RUN;
            end
            RUN:    if (hs && last)    state_d = DRAIN;
            DRAIN:  if (!v1_q)         state_d = REPORT;
            REPORT: if (mon.res_ready) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (hs) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stage 1: exact sum and absolute error distance of the accepted sample.
    assign exact  = {1'b0, mon.a} + {1'b0, mon.b};
    assign approx = {mon.approx_cout, mon.approx_s};
    assign ed     = (exact >= approx) ? (exact - approx) : (approx - exact);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            ed1_q <= '0;
        end else begin
            v1_q <= hs;
            if (hs) ed1_q <= ed;
        end
    end

    // Stage 2: accumulate; clear on a frame start has priority.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_q <= '0;
            max_q <= '0;
            sum_q <= '0;
        end else if (v1_q) begin
            sum_q <= sum_q + SUM_W'(ed1_q);
            err_q <= err_q + CNT_W'(ed1_q != 9'd0);
            if (ed1_q > max_q) max_q <= ed1_q;
        end
    end

`ifdef APPROX_MON_BIAS_EN
    logic signed [9:0]    sed;
    logic signed [9:0]    sed1_q;
    logic signed [SUM_W:0] bias_q;

    assign sed = $signed({1'b0, exact}) - $signed({1'b0, approx});

    always_ff @(posedge clk) begin
        if (rst) begin
            sed1_q <= '0;
        end else if (hs) begin
            sed1_q <= sed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            bias_q <= '0;
        end else if (v1_q) begin
            bias_q <= bias_q + (SUM_W+1)'(sed1_q);
        end
    end

    assign mon.bias_sum = bias_q;
`endif

    assign mon.in_ready  = (state_q == RUN);
    assign mon.res_valid = (state_q == REPORT);
    assign busy_o        = (state_q == RUN) || (state_q == DRAIN);
    assign mon.err_count = err_q;
    assign mon.max_ed    = max_q;
    assign mon.sum_ed    = sum_q;
endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Directed bench: FRAME_LEN=4 instance for most scenarios, FRAME_LEN=1 for the single-sample frame.
module tb_approx_adder_error_monitor;
    logic clk = 1'b0;
    logic rst;
    logic start4, start1;
    logic busy4, busy1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    approx_adder_error_monitor_if #(.CNT_W(16), .SUM_W(25)) i4 ();
    approx_adder_error_monitor_if #(.CNT_W(16), .SUM_W(25)) i1 ();

    approx_adder_error_monitor #(.FRAME_LEN(4), .CNT_W(16), .SUM_W(25)) dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .busy_o(busy4), .mon(i4.slave));
    approx_adder_error_monitor #(.FRAME_LEN(1), .CNT_W(16), .SUM_W(25)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .busy_o(busy1), .mon(i1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered and left on a negedge; returns once the sample was handshaken.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ap);
        int n = 0;
        i4.a = a; i4.b = b; i4.approx_cout = ap[8]; i4.approx_s = ap[7:0];
        i4.in_valid = 1'b1;
        while (!i4.in_ready && n < 50) begin @(negedge clk); n++; end
        chk("send_timeout", 32'(n < 50), 32'd1);
        @(negedge clk);
        i4.in_valid = 1'b0;
    endtask

    task automatic gap_junk();
        i4.a = 8'hAA; i4.b = 8'h55; i4.approx_cout = 1'b0; i4.approx_s = 8'h00;
        i4.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_res();
        int n = 0;
        while (!i4.res_valid && n < 50) begin @(negedge clk); n++; end
        chk("res_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic pulse_start();
        start4 = 1'b1; @(negedge clk); start4 = 1'b0;
    endtask

    task automatic stats(input string tag, input int e, input int m, input int s, input int bias);
        chk({tag, "_err"}, 32'(i4.err_count), 32'(e));
        chk({tag, "_max"}, 32'(i4.max_ed), 32'(m));
        chk({tag, "_sum"}, 32'(i4.sum_ed), 32'(s));
`ifdef APPROX_MON_BIAS_EN
        chk({tag, "_bias"}, 32'($signed(i4.bias_sum)), 32'(bias));
`else
        if (bias == 32'h7fffffff) chk({tag, "_bias_unused"}, 32'(bias), 32'd0);
`endif
    endtask

    task automatic scen2_frame(input bit gaps);
        send(8'hC0, 8'hC0, 9'h0C0); if (gaps) gap_junk();
        send(8'h01, 8'h01, 9'h002); if (gaps) gap_junk();
        send(8'hFF, 8'h01, 9'h0FF); if (gaps) gap_junk();
        send(8'h10, 8'h20, 9'h031);
    endtask

    task automatic ack();
        i4.res_ready = 1'b1; @(negedge clk); i4.res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start4 = 1'b0; start1 = 1'b0;
        i4.in_valid = 0; i4.a = 0; i4.b = 0; i4.approx_s = 0; i4.approx_cout = 0; i4.res_ready = 0;
        i1.in_valid = 0; i1.a = 0; i1.b = 0; i1.approx_s = 0; i1.approx_cout = 0; i1.res_ready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(i4.in_ready), 32'd0);
        chk("rst_res_valid", 32'(i4.res_valid), 32'd0);
        chk("rst_busy", 32'(busy4), 32'd0);
        stats("rst", 0, 0, 0, 0);

        // Samples offered in IDLE are not consumed
        i4.a = 8'hC0; i4.b = 8'hC0; i4.approx_cout = 0; i4.approx_s = 0; i4.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", 32'(i4.in_ready), 32'd0);
        i4.in_valid = 1'b0;

        // 1: error-free frame
        pulse_start();
        chk("run_busy", 32'(busy4), 32'd1);
        chk("run_in_ready", 32'(i4.in_ready), 32'd1);
        repeat (4) send(8'h0F, 8'h01, 9'h010);
        chk("drain_in_ready", 32'(i4.in_ready), 32'd0);
        wait_res();
        chk("rep_busy", 32'(busy4), 32'd0);
        stats("s1", 0, 0, 0, 0);
        ack();
        chk("s1_idle_res_valid", 32'(i4.res_valid), 32'd0);

        // 2: mixed errors, back-to-back
        pulse_start();
        scen2_frame(1'b0);
        wait_res();
        stats("s2", 3, 192, 194, 192);
        ack();
        stats("s2_idle_hold", 3, 192, 194, 192);

        // 3: gapped input with junk, held report
        pulse_start();
        scen2_frame(1'b1);
        wait_res();
        for (int k = 0; k < 5; k++) begin
            chk("s3_hold_valid", 32'(i4.res_valid), 32'd1);
            stats("s3_hold", 3, 192, 194, 192);
            @(negedge clk);
        end
        ack();
        chk("s3_idle_res_valid", 32'(i4.res_valid), 32'd0);
        chk("s3_idle_busy", 32'(busy4), 32'd0);

        // 4: reset mid-frame, then a fresh frame
        pulse_start();
        send(8'hC0, 8'hC0, 9'h0C0);
        send(8'h01, 8'h01, 9'h002);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("s4_in_ready", 32'(i4.in_ready), 32'd0);
        chk("s4_busy", 32'(busy4), 32'd0);
        chk("s4_res_valid", 32'(i4.res_valid), 32'd0);
        stats("s4_rst", 0, 0, 0, 0);
        pulse_start();
        repeat (4) send(8'hFF, 8'h01, 9'h0FF);
        wait_res();
        stats("s4", 4, 1, 4, 4);
        ack();

        // 5: start in RUN and in REPORT ignored, start in IDLE clears
        pulse_start();
        send(8'hC0, 8'hC0, 9'h0C0);
        send(8'h01, 8'h01, 9'h002);
        pulse_start();
        send(8'hFF, 8'h01, 9'h0FF);
        send(8'h10, 8'h20, 9'h031);
        wait_res();
        stats("s5_run_start", 3, 192, 194, 192);
        pulse_start();
        chk("s5_rep_start_valid", 32'(i4.res_valid), 32'd1);
        stats("s5_rep_start", 3, 192, 194, 192);
        start4 = 1'b1; i4.res_ready = 1'b1;
        @(negedge clk);
        start4 = 1'b0; i4.res_ready = 1'b0;
        chk("s5_ack_start_busy", 32'(busy4), 32'd0);
        chk("s5_ack_start_in_ready", 32'(i4.in_ready), 32'd0);
        stats("s5_ack_start", 3, 192, 194, 192);
        pulse_start();
        stats("s5_idle_start", 0, 0, 0, 0);
        chk("s5_idle_start_busy", 32'(busy4), 32'd1);

        // 6: FRAME_LEN=1
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        chk("s6_in_ready", 32'(i1.in_ready), 32'd1);
        i1.a = 8'h80; i1.b = 8'h80; i1.approx_cout = 1'b0; i1.approx_s = 8'h00; i1.in_valid = 1'b1;
        @(negedge clk);
        i1.in_valid = 1'b0;
        chk("s6_in_ready_after", 32'(i1.in_ready), 32'd0);
        chk("s6_busy", 32'(busy1), 32'd1);
        @(negedge clk);
        chk("s6_res_valid_early", 32'(i1.res_valid), 32'd0);
        @(negedge clk);
        chk("s6_res_valid", 32'(i1.res_valid), 32'd1);
        chk("s6_err", 32'(i1.err_count), 32'd1);
        chk("s6_max", 32'(i1.max_ed), 32'd256);
        chk("s6_sum", 32'(i1.sum_ed), 32'd256);
`ifdef APPROX_MON_BIAS_EN
        chk("s6_bias", 32'($signed(i1.bias_sum)), 32'd256);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
